// File: rtl/seg7_score_ctrl.sv
// rtl/seg7_score_ctrl.sv - binary-to-BCD score/level controller for an 8-digit display
//
// Purpose:
//   Accepts binary score and level requests and arbitrates between them
//   round-robin. The granted value is saturated to SAT_MAX and converted to
//   4-digit BCD by a serial double-dabble, one step per cycle. The result is
//   written into its half of the packed display word x.
//
// Configuration macro: SEG7_HISCORE_EN
//   When defined, x[31:16] shows an internal hiscore. Each score conversion
//   that beats the stored hiscore updates it. The level inputs are ignored.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   clr        in   1   asynchronous active-high reset
//   score      in  14   binary score
//   score_vld  in   1   score request, held until score_ack
//   score_ack  out  1   one-cycle grant pulse for score
//   level      in  14   binary level
//   level_vld  in   1   level request, held until level_ack
//   level_ack  out  1   one-cycle grant pulse for level
//   x          out 32   BCD word: [15:0] score, [31:16] level or hiscore
//   busy       out  1   conversion in progress
//   ovf        out  1   sticky: an accepted input exceeded SAT_MAX

module seg7_score_ctrl #(
  parameter int SAT_MAX = 9999
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [13:0] score,
  input  logic        score_vld,
  output logic        score_ack,
  input  logic [13:0] level,
  input  logic        level_vld,
  output logic        level_ack,
  output logic [31:0] x,
  output logic        busy,
  output logic        ovf
);

  localparam logic [13:0] LP_SAT = 14'(SAT_MAX);

  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_is_level;
  logic        r_rr;        // 1: level has priority on the next contested grant
  logic        r_score_ack;
  logic        r_level_ack;
  logic        r_ovf;
  logic [31:0] r_x;

  logic        w_req_s;
  logic        w_req_l;
  logic        w_start;
  logic        w_pick_level;
  logic [13:0] w_raw;
  logic        w_over;
  logic [13:0] w_sat;
  logic [15:0] w_adj;

`ifdef SEG7_HISCORE_EN
  logic [13:0] r_val;
  logic [13:0] r_hiscore;
  logic        w_unused;
  assign w_unused = ^{level, level_vld};
  assign w_req_l  = 1'b0;
`else
  assign w_req_l  = level_vld;
`endif
  assign w_req_s  = score_vld;

  assign w_raw  = w_pick_level ? level : score;
  assign w_over = (w_raw > LP_SAT);
  assign w_sat  = w_over ? LP_SAT : w_raw;

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after
  // the shift, so bias it by 3 first.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_pick_level = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_s || w_req_l) begin
          w_next       = CONV;
          w_start      = 1'b1;
          w_pick_level = w_req_l && (!w_req_s || r_rr);
        end
      end
      CONV: begin
        if (r_cnt == 4'd13) begin
          w_next = WRITE;
        end
      end
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_is_level  <= 1'b0;
      r_rr        <= 1'b0;
      r_score_ack <= 1'b0;
      r_level_ack <= 1'b0;
      r_ovf       <= 1'b0;
      r_x         <= '0;
`ifdef SEG7_HISCORE_EN
      r_val       <= '0;
      r_hiscore   <= '0;
`endif
    end else begin
      r_state     <= w_next;
      r_score_ack <= 1'b0;
      r_level_ack <= 1'b0;
      if (w_start) begin
        r_bin       <= w_sat;
        r_bcd       <= '0;
        r_cnt       <= '0;
        r_is_level  <= w_pick_level;
        r_score_ack <= !w_pick_level;
        r_level_ack <= w_pick_level;
        if (w_over) begin
          r_ovf <= 1'b1;
        end
        // The pointer moves only when both sides competed. A requester that
        // wins alone does not use up its turn.
        if (w_req_s && w_req_l) begin
          r_rr <= !w_pick_level;
        end
`ifdef SEG7_HISCORE_EN
        r_val <= w_sat;
`endif
      end
      if (r_state == CONV) begin
        r_bcd <= {w_adj[14:0], r_bin[13]};
        r_bin <= {r_bin[12:0], 1'b0};
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == WRITE) begin
        if (r_is_level) begin
          r_x[31:16] <= r_bcd;
        end else begin
          r_x[15:0] <= r_bcd;
`ifdef SEG7_HISCORE_EN
          if (r_val > r_hiscore) begin
            r_hiscore  <= r_val;
            r_x[31:16] <= r_bcd;
          end
`endif
        end
      end
    end
  end

  assign score_ack = r_score_ack;
  assign level_ack = r_level_ack;
  assign x         = r_x;
  assign busy      = (r_state != IDLE);
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seg7_score_ctrl.sv
// tb/tb_seg7_score_ctrl.sv - directed self-checking bench for seg7_score_ctrl

module tb_seg7_score_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [13:0] score;
  logic        score_vld;
  logic [13:0] level;
  logic        level_vld;
  logic        score_ack;
  logic        level_ack;
  logic [31:0] x;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic quiet;

  seg7_score_ctrl #(.SAT_MAX(9999)) dut (
    .clk       (clk),
    .clr       (clr),
    .score     (score),
    .score_vld (score_vld),
    .score_ack (score_ack),
    .level     (level),
    .level_vld (level_vld),
    .level_ack (level_ack),
    .x         (x),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Wait for a grant, then check the ack pulse, the busy length and the final x.
  task automatic run_conv(input string tag, input logic exp_lvl, input logic [31:0] exp_x,
                          output int glat);
    int   bcnt;
    logic seen;
    seen = 1'b0;
    glat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (score_ack || level_ack) begin
        seen = 1'b1;
        glat = i;
      end
    end
    if (!seen) begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_ack"}, {30'd0, level_ack, score_ack}, exp_lvl ? 32'd2 : 32'd1);
    if (exp_lvl) level_vld = 1'b0;
    else         score_vld = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (i == 1) check({tag, "_ack_pulse"}, {30'd0, level_ack, score_ack}, 32'd0);
      bcnt++;
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, bcnt, 32'd15);
    check({tag, "_x"}, x, exp_x);
  endtask

  initial begin
    clr = 1'b1; score = '0; level = '0; score_vld = 1'b0; level_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_x", x, 32'd0);
    check("reset_flags", {28'd0, busy, ovf, score_ack, level_ack}, 32'd0);
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_flags", {28'd0, busy, ovf, score_ack, level_ack}, 32'd0);

`ifdef SEG7_HISCORE_EN
    level = 14'd7; level_vld = 1'b1;
    score = 14'd300; score_vld = 1'b1;
    run_conv("hs300", 1'b0, 32'h0300_0300, lat);
    score = 14'd120; score_vld = 1'b1;
    run_conv("hs120", 1'b0, 32'h0300_0120, lat);
    score = 14'd950; score_vld = 1'b1;
    run_conv("hs950", 1'b0, 32'h0950_0950, lat);
    repeat (20) @(posedge clk);
    #1;
    check("hs_level_ack", {31'd0, level_ack}, 32'd0);
    check("hs_busy_idle", {31'd0, busy}, 32'd0);
    level_vld = 1'b0;
`else
    score = 14'd1234; score_vld = 1'b1;
    run_conv("s1234", 1'b0, 32'h0000_1234, lat);
    check("s1234_ovf", {31'd0, ovf}, 32'd0);

    score = 14'd16383; score_vld = 1'b1;
    run_conv("s_sat", 1'b0, 32'h0000_9999, lat);
    check("s_sat_ovf", {31'd0, ovf}, 32'd1);
    score = 14'd5; score_vld = 1'b1;
    run_conv("s5", 1'b0, 32'h0000_0005, lat);
    check("s5_ovf_sticky", {31'd0, ovf}, 32'd1);

    // Contested pair: score wins first, then level at N+16.
    score = 14'd42; level = 14'd7; score_vld = 1'b1; level_vld = 1'b1;
    run_conv("pair1_a", 1'b0, 32'h0000_0042, lat);
    run_conv("pair1_b", 1'b1, 32'h0007_0042, lat);
    check("pair1_b_lat", lat, 32'd0);

    // Repeat the pair: level wins the second contest.
    score = 14'd58; level = 14'd13; score_vld = 1'b1; level_vld = 1'b1;
    run_conv("pair2_a", 1'b1, 32'h0013_0042, lat);
    run_conv("pair2_b", 1'b0, 32'h0013_0058, lat);
    check("pair2_b_lat", lat, 32'd0);

    level = 14'd9999; level_vld = 1'b1;
    run_conv("l9999", 1'b1, 32'h9999_0058, lat);
    level = 14'd0; level_vld = 1'b1;
    run_conv("l0", 1'b1, 32'h0000_0058, lat);
`endif

    // Abort a conversion with clr; check asynchronously before the next edge.
    score = 14'd777; score_vld = 1'b1;
    quiet = 1'b0;
    for (int i = 0; i < 40 && !quiet; i++) begin
      @(posedge clk); #1;
      if (score_ack) quiet = 1'b1;
    end
    check("abort_grant", {31'd0, quiet}, 32'd1);
    score_vld = 1'b0;
    repeat (5) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("abort_x", x, 32'd0);
    check("abort_flags", {28'd0, busy, ovf, score_ack, level_ack}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (score_ack || level_ack || busy || (x != 32'd0)) quiet = 1'b0;
    end
    check("abort_quiet", {31'd0, quiet}, 32'd1);

`ifndef SEG7_HISCORE_EN
    // Level overflow after a reset sets ovf again.
    level = 14'd10000; level_vld = 1'b1;
    run_conv("l_sat", 1'b1, 32'h9999_0000, lat);
    check("l_sat_ovf", {31'd0, ovf}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
